store_trace_fifo: RTL and testbench

//   Sits directly downstream of the single-cycle CPU top's data-memory store port
//   (memwrite/dataadr/writedata). Captures every committed store into a FIFO and

---
 rtl/store_trace_fifo.sv | 110 +++++++++++
 tb/tb_store_trace_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_trace_fifo.sv
// Store trace FIFO: captures every committed CPU store and drains it over valid/ready.
// Also flags a sticky "completion" store (WATCH_DATA written to WATCH_ADDR).
`timescale 1ns/1ps
module store_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter logic [AW-1:0] WATCH_ADDR = AW'(20),
    parameter logic [DW-1:0] WATCH_DATA = DW'(100)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clear,
    input  logic                         i_memwrite,
    input  logic [AW-1:0]                i_dataadr,
    input  logic [DW-1:0]                i_writedata,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [AW-1:0]                o_out_addr,
    output logic [DW-1:0]                o_out_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow,
    output logic [7:0]                   o_drops,
    output logic                         o_hit
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] r_addr_mem [DEPTH];
    logic [DW-1:0] r_data_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [7:0]    r_drops;
    logic          r_hit;

    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_hit_set;

    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = w_valid && i_out_ready && !i_clear;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the store.
    assign w_push    = i_memwrite && (!w_full || w_pop) && !i_clear;
    assign w_drop    = i_memwrite && w_full && !w_pop && !i_clear;
    assign w_hit_set = i_memwrite && (i_dataadr == WATCH_ADDR) && (i_writedata == WATCH_DATA);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= i_dataadr;
            r_data_mem[r_wr_ptr] <= i_writedata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drops    <= 8'd0;
            r_hit      <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drops    <= 8'd0;
            r_hit      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drops != 8'hFF) begin
                    r_drops <= r_drops + 8'd1;
                end
            end
            if (w_hit_set) begin
                r_hit <= 1'b1;
            end
        end
    end

    // Head is gated by valid so stale storage never leaks out after reset/clear.
    assign o_out_valid = w_valid;
    assign o_out_addr  = w_valid ? r_addr_mem[r_rd_ptr] : '0;
    assign o_out_data  = w_valid ? r_data_mem[r_rd_ptr] : '0;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_drops     = r_drops;
    assign o_hit       = r_hit;

endmodule

// File: tb/tb_store_trace_fifo.sv
// Bench for store_trace_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_store_trace_fifo;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        mw = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wd = '0;

    logic        o_valid;
    logic [31:0] o_addr;
    logic [31:0] o_data;
    logic [3:0]  o_count;
    logic        o_ovf;
    logic [7:0]  o_drops;
    logic        o_hit;

    int n_cmp = 0;
    int n_bad = 0;

    store_trace_fifo #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clear     (clear),
        .i_memwrite  (mw),
        .i_dataadr   (adr),
        .i_writedata (wd),
        .o_out_valid (o_valid),
        .i_out_ready (rdy),
        .o_out_addr  (o_addr),
        .o_out_data  (o_data),
        .o_count     (o_count),
        .o_overflow  (o_ovf),
        .o_drops     (o_drops),
        .o_hit       (o_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {addr,data} plus sticky flags.
    logic [63:0] mq[$];
    bit          m_ovf;
    bit          m_hit;
    int          m_drops;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            mq.delete();
            m_ovf   = 0;
            m_hit   = 0;
            m_drops = 0;
        end else begin
            bit p;
            p = (mq.size() > 0) && rdy;
            if (mw && adr == 32'd20 && wd == 32'd100) m_hit = 1;
            if (p) void'(mq.pop_front());
            if (mw) begin
                if (mq.size() < DEPTH) mq.push_back({adr, wd});
                else begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
    end

    logic [63:0] log_q[$];

    always @(negedge clk) begin
        chk("valid", {63'd0, o_valid}, {63'd0, mq.size() != 0});
        chk("count", {60'd0, o_count}, 64'(mq.size()));
        if (mq.size() != 0) begin
            chk("addr", {32'd0, o_addr}, {32'd0, mq[0][63:32]});
            chk("data", {32'd0, o_data}, {32'd0, mq[0][31:0]});
        end else begin
            chk("addr_idle", {32'd0, o_addr}, 64'd0);
            chk("data_idle", {32'd0, o_data}, 64'd0);
        end
        chk("overflow", {63'd0, o_ovf}, {63'd0, m_ovf});
        chk("drops", {56'd0, o_drops}, 64'(m_drops));
        chk("hit", {63'd0, o_hit}, {63'd0, m_hit});
        if (o_valid && rdy) log_q.push_back({o_addr, o_data});
    end

    task automatic drive(input bit m, input logic [31:0] a, input logic [31:0] d, input bit r);
        @(posedge clk);
        #1;
        mw = m; adr = a; wd = d; rdy = r;
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1;
        clear = 1'b1; mw = 1'b1; adr = 32'd20; wd = 32'd100; rdy = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0; mw = 1'b0; rdy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            mw = 1'($urandom); adr = $urandom; wd = $urandom;
            rdy = 1'($urandom); clear = 1'($urandom);
            #1;
            chk("rst_valid", {63'd0, o_valid}, 64'd0);
            chk("rst_count", {60'd0, o_count}, 64'd0);
            chk("rst_addr", {32'd0, o_addr}, 64'd0);
            chk("rst_drops", {56'd0, o_drops}, 64'd0);
        end
        @(posedge clk);
        #1;
        mw = 0; adr = 0; wd = 0; rdy = 0; clear = 0; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_valid", {63'd0, o_valid}, 64'd0);
        chk("post_rst_hit", {63'd0, o_hit}, 64'd0);

        // 2: program stores (30,100) then (20,100), consumer always ready
        log_q.delete();
        drive(1, 32'd30, 32'd100, 1);
        drive(1, 32'd20, 32'd100, 1);
        repeat (3) drive(0, 0, 0, 1);
        @(negedge clk);
        chk("t2_log_n", 64'(log_q.size()), 64'd2);
        if (log_q.size() == 2) begin
            chk("t2_e0", log_q[0], {32'd30, 32'd100});
            chk("t2_e1", log_q[1], {32'd20, 32'd100});
        end
        chk("t2_hit", {63'd0, o_hit}, 64'd1);
        chk("t2_count", {60'd0, o_count}, 64'd0);
        chk("t2_ovf", {63'd0, o_ovf}, 64'd0);

        // 3: overfill with consumer stalled
        do_clear();
        for (int k = 0; k < 10; k++) drive(1, 32'(k), 32'(100 + k), 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("t3_count", {60'd0, o_count}, 64'd8);
        chk("t3_ovf", {63'd0, o_ovf}, 64'd1);
        chk("t3_drops", {56'd0, o_drops}, 64'd2);
        log_q.delete();
        repeat (10) drive(0, 0, 0, 1);
        @(negedge clk);
        chk("t3_log_n", 64'(log_q.size()), 64'd8);
        for (int k = 0; k < 8 && k < log_q.size(); k++)
            chk("t3_entry", log_q[k], {32'(k), 32'(100 + k)});

        // 4: full FIFO with simultaneous push and pop across pointer wrap
        for (int k = 0; k < 8; k++) drive(1, 32'(40 + k), 32'(200 + k), 0);
        log_q.delete();
        for (int j = 0; j < 5; j++) drive(1, 32'(48 + j), 32'(208 + j), 1);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("t4_count", {60'd0, o_count}, 64'd8);
        chk("t4_drops", {56'd0, o_drops}, 64'd2);
        repeat (10) drive(0, 0, 0, 1);
        @(negedge clk);
        chk("t4_log_n", 64'(log_q.size()), 64'd13);
        for (int i = 0; i < 13 && i < log_q.size(); i++)
            chk("t4_entry", log_q[i], {32'(40 + i), 32'(200 + i)});

        // 5: watch-store matching and clear
        do_clear();
        drive(1, 32'd20, 32'd99, 1);
        drive(1, 32'd21, 32'd100, 1);
        drive(0, 0, 0, 1);
        @(negedge clk);
        chk("t5_hit_near", {63'd0, o_hit}, 64'd0);
        drive(1, 32'd20, 32'd100, 1);
        @(negedge clk);
        chk("t5_hit_before_edge", {63'd0, o_hit}, 64'd0);
        drive(0, 0, 0, 1);
        @(negedge clk);
        chk("t5_hit_set", {63'd0, o_hit}, 64'd1);
        do_clear();
        @(negedge clk);
        chk("t5_hit_clr", {63'd0, o_hit}, 64'd0);
        chk("t5_count_clr", {60'd0, o_count}, 64'd0);

        // 6: async reset mid-drain
        for (int k = 0; k < 5; k++) drive(1, 32'(60 + k), 32'(600 + k), 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("t6_count5", {60'd0, o_count}, 64'd5);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {63'd0, o_valid}, 64'd0);
        chk("t6_rst_count", {60'd0, o_count}, 64'd0);
        #2 rst_n = 1'b1;
        drive(1, 32'd77, 32'd777, 0);
        @(negedge clk);
        chk("t6_pre_valid", {63'd0, o_valid}, 64'd0);
        @(posedge clk);
        #1;
        mw = 1'b0;
        chk("t6_valid", {63'd0, o_valid}, 64'd1);
        chk("t6_addr", {32'd0, o_addr}, 64'd77);
        chk("t6_data", {32'd0, o_data}, 64'd777);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
